// File: rtl/inj_pulse_seq.sv
// Injection pulse sequencer: delayed burst of programmable-width/period pulses on INJ.
// Optional hit counting is enabled by defining INJ_HIT_COUNT_EN.
module inj_pulse_seq #(
    parameter int unsigned CW = 16,
    parameter int unsigned NW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          ABORT,
    input  logic [CW-1:0] DELAY,
    input  logic [CW-1:0] WIDTH,
    input  logic [CW-1:0] PERIOD,
    input  logic [NW-1:0] COUNT,
    input  logic          HIT,
    output logic          INJ,
    output logic          BUSY,
    output logic          DONE,
    output logic [NW-1:0] PULSE_CNT,
    output logic [NW-1:0] HIT_CNT
);

    typedef enum logic [1:0] {IDLE, DLY, HIGH, LOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] w_q, w_d;
    logic [CW-1:0] l_q, l_d;
    logic [NW-1:0] tgt_q, tgt_d;
    logic [NW-1:0] pcnt_q, pcnt_d;
    logic          inj_q, inj_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          start_go;
    logic [CW-1:0] w_in;
    logic [CW:0]   l_diff;
    logic [CW-1:0] l_in;
    logic [NW-1:0] pcnt_inc;

    assign start_go = (state_q == IDLE) && START && !ABORT;
    assign w_in     = (WIDTH == '0) ? CW'(1) : WIDTH;
    // Extra bit catches PERIOD < W; underflow or zero both clamp the low phase to 1
    assign l_diff   = {1'b0, PERIOD} - {1'b0, w_in};
    assign l_in     = (l_diff[CW] || (l_diff[CW-1:0] == '0)) ? CW'(1) : l_diff[CW-1:0];
    assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + NW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            w_q     <= '0;
            l_q     <= '0;
            tgt_q   <= '0;
            pcnt_q  <= '0;
            inj_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            w_q     <= w_d;
            l_q     <= l_d;
            tgt_q   <= tgt_d;
            pcnt_q  <= pcnt_d;
            inj_q   <= inj_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        w_d     = w_q;
        l_d     = l_q;
        tgt_d   = tgt_q;
        pcnt_d  = pcnt_q;
        if (state_q != IDLE && ABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_go) begin
                        state_d = DLY;
                        tmr_d   = DELAY;
                        w_d     = w_in;
                        l_d     = l_in;
                        tgt_d   = COUNT;
                        pcnt_d  = '0;
                    end
                end
                DLY: begin
                    if (tmr_q == '0) begin
                        state_d = HIGH;
                        tmr_d   = w_q - CW'(1);
                        pcnt_d  = pcnt_inc;
                    end else begin
                        tmr_d = tmr_q - CW'(1);
                    end
                end
                HIGH: begin
                    if (tmr_q == '0) begin
                        state_d = LOW;
                        tmr_d   = l_q - CW'(1);
                    end else begin
                        tmr_d = tmr_q - CW'(1);
                    end
                end
                LOW: begin
                    if (tmr_q == '0) begin
                        if (tgt_q != '0 && pcnt_q == tgt_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = HIGH;
                            tmr_d   = w_q - CW'(1);
                            pcnt_d  = pcnt_inc;
                        end
                    end else begin
                        tmr_d = tmr_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so INJ comes straight off a flop
    always_comb begin
        inj_d  = (state_d == HIGH);
        busy_d = (state_d != IDLE);
        done_d = (state_q == LOW) && (state_d == IDLE) && !ABORT;
    end

    assign INJ       = inj_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PULSE_CNT = pcnt_q;

`ifdef INJ_HIT_COUNT_EN
    logic [2:0]    hit_sync_q;
    logic [NW-1:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (start_go) begin
            hit_cnt_d = '0;
        end else if (hit_sync_q[1] && !hit_sync_q[2] &&
                     (state_q == HIGH || state_q == LOW) && hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + NW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_sync_q <= '0;
            hit_cnt_q  <= '0;
        end else begin
            hit_sync_q <= {hit_sync_q[1:0], HIT};
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign HIT_CNT = hit_cnt_q;
`else
    logic unused_hit;
    assign unused_hit = HIT;
    assign HIT_CNT    = '0;
`endif

endmodule

// File: tb/tb_inj_pulse_seq.sv
// Scoreboard bench for inj_pulse_seq: expected rise/done cycles queued at START, checked by a monitor.
module tb_inj_pulse_seq;

    localparam int CW = 16;
    localparam int NW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic          HIT = 1'b0;
    logic [CW-1:0] DELAY = '0;
    logic [CW-1:0] WIDTH = '0;
    logic [CW-1:0] PERIOD = '0;
    logic [NW-1:0] COUNT = '0;
    logic          INJ, BUSY, DONE;
    logic [NW-1:0] PULSE_CNT, HIT_CNT;

    inj_pulse_seq #(.CW(CW), .NW(NW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .DELAY(DELAY), .WIDTH(WIDTH), .PERIOD(PERIOD), .COUNT(COUNT),
        .HIT(HIT), .INJ(INJ), .BUSY(BUSY), .DONE(DONE),
        .PULSE_CNT(PULSE_CNT), .HIT_CNT(HIT_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

`ifdef INJ_HIT_COUNT_EN
    localparam int HITS_EXP = 5;
`else
    localparam int HITS_EXP = 0;
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    int   exp_rise[$];
    int   exp_done[$];
    int   exp_pc[$];
    int   exp_hc[$];
    int   cur_w = 1;
    bit   aborting = 0;
    int   last_rise = 0;
    int   e_tmp;
    logic inj_prev = 1'b0;
    logic done_prev = 1'b0;

    always @(negedge CLK) begin
        if (INJ === 1'b1 && inj_prev === 1'b0) begin
            e_tmp = (exp_rise.size() != 0) ? exp_rise.pop_front() : -1;
            check("inj_rise", cyc, e_tmp);
            last_rise = cyc;
        end
        if (INJ === 1'b0 && inj_prev === 1'b1 && !aborting)
            check("inj_width", cyc - last_rise, cur_w);
        if (DONE === 1'b1) begin
            e_tmp = (exp_done.size() != 0) ? exp_done.pop_front() : -1;
            check("done_cyc", cyc, e_tmp);
            e_tmp = (exp_pc.size() != 0) ? exp_pc.pop_front() : -1;
            check("done_pulse_cnt", PULSE_CNT, e_tmp);
            e_tmp = (exp_hc.size() != 0) ? exp_hc.pop_front() : -1;
            check("done_hit_cnt", HIT_CNT, e_tmp);
            check("done_busy", BUSY, 0);
        end
        if (done_prev === 1'b1) check("done_len", DONE, 0);
        inj_prev  = INJ;
        done_prev = DONE;
    end

    task automatic run_burst(input int d, input int w, input int p, input int c, input int hits);
        int we, le, k, n;
        @(negedge CLK);
        DELAY = CW'(d); WIDTH = CW'(w); PERIOD = CW'(p); COUNT = NW'(c);
        START = 1'b1;
        aborting = 0;
        we = (w == 0) ? 1 : w;
        le = p - we;
        if (le < 1) le = 1;
        cur_w = we;
        k = cyc + 1;
        n = (c == 0) ? 5 : c;
        for (int i = 0; i < n; i++) exp_rise.push_back(k + 1 + d + i * (we + le));
        if (c != 0) begin
            exp_done.push_back(k + 1 + d + c * (we + le));
            exp_pc.push_back(c);
            exp_hc.push_back(hits);
        end
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        DELAY = CW'($urandom); WIDTH = CW'($urandom); PERIOD = CW'($urandom); COUNT = NW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (BUSY === 1'b0) break;
            @(negedge CLK);
        end
        check("burst_end_timeout", BUSY, 0);
        repeat (3) @(negedge CLK);
        check("rise_left", exp_rise.size(), 0);
        check("done_left", exp_done.size(), 0);
    endtask

    task automatic wait_inj(input logic level, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (INJ === level) break;
            @(negedge CLK);
        end
        check("wait_inj", INJ, level);
    endtask

    task automatic hit_pulse();
        HIT = 1'b1;
        repeat (2) @(negedge CLK);
        HIT = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            check("idle_outputs", |{INJ, BUSY, DONE, PULSE_CNT, HIT_CNT}, 0);
        end

        run_burst(3, 4, 10, 3, 0);
        wait_idle(200);

        run_burst(0, 0, 0, 2, 0);
        wait_idle(100);

        run_burst(1, 7, 3, 2, 0);
        wait_idle(100);

        // START mid-burst with random fields must not disturb the running burst
        run_burst(2, 5, 12, 2, 0);
        repeat (6) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_idle(200);

        run_burst(1, 4, 9, 0, 0);
        for (int i = 0; i < 200; i++) begin
            if (PULSE_CNT === NW'(5) && INJ === 1'b1) break;
            @(negedge CLK);
        end
        check("abort_reach_5th", PULSE_CNT, 5);
        aborting = 1;
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_inj", INJ, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_pulse_cnt", PULSE_CNT, 5);
        repeat (5) @(negedge CLK);
        check("abort_pulse_hold", PULSE_CNT, 5);
        check("abort_rise_left", exp_rise.size(), 0);

        @(negedge CLK);
        START = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        check("start_abort_busy", BUSY, 0);
        repeat (10) @(negedge CLK);
        check("start_abort_idle", BUSY, 0);

        run_burst(2, 3, 8, 4, 0);
        for (int i = 0; i < 200; i++) begin
            if (PULSE_CNT === NW'(2) && INJ === 1'b0) break;
            @(negedge CLK);
        end
        check("rst_reach_low", PULSE_CNT, 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_mid_outputs", |{INJ, BUSY, DONE, PULSE_CNT, HIT_CNT}, 0);
        exp_rise.delete(); exp_done.delete(); exp_pc.delete(); exp_hc.delete();
        run_burst(1, 2, 5, 3, 0);
        wait_idle(200);

        hit_pulse();
        repeat (6) @(negedge CLK);
        run_burst(2, 3, 8, 5, HITS_EXP);
        for (int i = 0; i < 5; i++) begin
            wait_inj(1'b0, 50);
            wait_inj(1'b1, 50);
            hit_pulse();
        end
        wait_idle(200);
        hit_pulse();
        repeat (6) @(negedge CLK);
        check("hit_after_burst", HIT_CNT, HITS_EXP);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
